// File: rtl/vout_fpdlink.sv
// vout_fpdlink: dual-pixel FPD-Link transmit timing, Y4-to-grey RGB666 expansion and 42-bit serializer packing
module vout_fpdlink #(
  parameter int H_ACT  = 800,
  parameter int H_FP   = 24,
  parameter int H_SYNC = 16,
  parameter int H_BP   = 40,
  parameter int V_ACT  = 1200,
  parameter int V_FP   = 3,
  parameter int V_SYNC = 3,
  parameter int V_BP   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        frame_start,
  output logic        underflow,
  output logic [41:0] fpdlink_dout
);
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam logic [HW-1:0] H_A  = HW'(H_ACT);
  localparam logic [HW-1:0] H_S0 = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] H_S1 = HW'(H_ACT + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_L  = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_A  = VW'(V_ACT);
  localparam logic [VW-1:0] V_S0 = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] V_S1 = VW'(V_ACT + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_L  = VW'(V_TOT - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [41:0]   dout_q, dout_d;
  logic          fs_q, fs_d, uf_q, uf_d;
  logic          run, de, hs, vs, h_last, v_last, xfer;
  logic [5:0]    co, ce;
  always_comb begin
    run = state_q == RUN;
    de = (hcnt_q < H_A) & (vcnt_q < V_A);
    hs = (hcnt_q >= H_S0) & (hcnt_q < H_S1);
    vs = (vcnt_q >= V_S0) & (vcnt_q < V_S1);
    h_last = hcnt_q == H_L;
    v_last = vcnt_q == V_L;
    pix_ready = run & de & ~rst;
    xfer = pix_ready & pix_valid;
    co = xfer ? {pix_data[3:0], pix_data[3:2]} : 6'd0;
    ce = xfer ? {pix_data[7:4], pix_data[7:6]} : 6'd0;
    hcnt_d = run ? (h_last ? '0 : hcnt_q + 1'b1) : '0;
    vcnt_d = run ? (h_last ? (v_last ? '0 : vcnt_q + 1'b1) : vcnt_q) : '0;
    state_d = run ? ((h_last & v_last & ~en) ? IDLE : RUN) : (en ? RUN : IDLE);
    fs_d = run & (hcnt_q == '0) & (vcnt_q == '0);
    uf_d = (run & de & ~pix_valid) | (uf_q & ~fs_d);
    dout_d = run ? {co[0], co, co[1:0], co[5:1], de, vs, hs, co[5:2],
                    ce[0], ce, ce[1:0], ce[5:1], de, vs, hs, ce[5:2]} : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      dout_q  <= '0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      dout_q  <= dout_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end
  assign fpdlink_dout = dout_q;
  assign frame_start  = fs_q;
  assign underflow    = uf_q;
endmodule

// File: tb/tb_vout_fpdlink.sv
// tb_vout_fpdlink: directed/random bench for vout_fpdlink against a frame-position reference model
module tb_vout_fpdlink;
  logic        clk, rst, en, pix_valid, pix_ready, frame_start, underflow;
  logic [7:0]  pix_data;
  logic [41:0] fpdlink_dout;
  int errors = 0, checks = 0;
  int de_cnt, hs_cnt, vs_cnt, fs_cnt;
  bit m_run = 0, m_uf = 0;
  int m_pos = 0;
  vout_fpdlink #(.H_ACT(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                 .V_ACT(2), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut (
    .clk(clk), .rst(rst), .en(en), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .frame_start(frame_start), .underflow(underflow),
    .fpdlink_dout(fpdlink_dout));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [41:0] o, input logic [41:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", n, o, x);
    end
  endtask
  function automatic logic [5:0] x6(input logic [3:0] y);
    return 6'(int'(y) * 4 + int'(y) / 4);
  endfunction
  function automatic logic [20:0] unpack(input logic [20:0] w);
    return {w[6], w[5], w[4], w[19:14], w[11:7], w[20], w[3:0], w[13:12]};
  endfunction
  task automatic step(input logic r, input logic e, input logic v, input logic [7:0] d);
    int h, ln;
    bit run0, de, hs, vs, rdy, xfer, efs, euf;
    logic [5:0] co, ce;
    rst = r; en = e; pix_valid = v; pix_data = d;
    #1;
    run0 = m_run;
    h = m_pos % 8;
    ln = m_pos / 8;
    de = run0 && h < 4 && ln < 2;
    hs = h >= 5 && h <= 6;
    vs = ln == 3;
    rdy = de && !r;
    xfer = rdy && v;
    co = xfer ? x6(d[3:0]) : 6'd0;
    ce = xfer ? x6(d[7:4]) : 6'd0;
    chk("pix_ready", 42'(pix_ready), 42'(rdy));
    efs = run0 && m_pos == 0 && !r;
    euf = !r && ((rdy && !v) || (m_uf && !efs));
    if (r) begin
      m_run = 0; m_pos = 0;
    end else if (m_run) begin
      if (m_pos == 39) begin
        m_pos = 0;
        if (!e) m_run = 0;
      end else m_pos++;
    end else if (e) m_run = 1;
    m_uf = euf;
    @(posedge clk);
    #1;
    if (!run0 || r) chk("dout_zero", fpdlink_dout, 42'd0);
    else begin
      chk("odd_fields", 42'(unpack(fpdlink_dout[41:21])), 42'({de, vs, hs, co, co, co}));
      chk("even_fields", 42'(unpack(fpdlink_dout[20:0])), 42'({de, vs, hs, ce, ce, ce}));
    end
    chk("frame_start", 42'(frame_start), 42'(efs));
    chk("underflow", 42'(underflow), 42'(euf));
    de_cnt += int'(fpdlink_dout[27]);
    hs_cnt += int'(fpdlink_dout[25]);
    vs_cnt += int'(fpdlink_dout[26]);
    fs_cnt += int'(frame_start);
  endtask
  initial begin
    rst = 1; en = 0; pix_valid = 0; pix_data = 0;
    step(1, 0, 0, 8'h00);
    step(0, 1, 1, 8'($urandom));
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 80; i++) step(0, 1, 1, 8'($urandom));
    chk("de_per_2frames", 42'(de_cnt), 42'd16);
    chk("hs_per_2frames", 42'(hs_cnt), 42'd20);
    chk("vs_per_2frames", 42'(vs_cnt), 42'd16);
    chk("fs_per_2frames", 42'(fs_cnt), 42'd2);
    step(0, 1, 1, 8'hF0);
    chk("pk_even_r", 42'(fpdlink_dout[19:14]), 42'h3F);
    chk("pk_even_g", 42'({fpdlink_dout[11:7], fpdlink_dout[20]}), 42'h3F);
    chk("pk_even_b", 42'({fpdlink_dout[3:0], fpdlink_dout[13:12]}), 42'h3F);
    chk("pk_odd_col", 42'({fpdlink_dout[41:28], fpdlink_dout[24:21]}), 42'd0);
    chk("pk_de", 42'({fpdlink_dout[27], fpdlink_dout[6]}), 42'd3);
    chk("pk_y_even", 42'(fpdlink_dout[19:16]), 42'hF);
    chk("pk_y_odd", 42'(fpdlink_dout[40:37]), 42'h0);
    for (int i = 1; i < 40; i++) step(0, 1, 1, 8'(i));
    step(0, 1, 1, 8'($urandom));
    step(0, 1, 1, 8'($urandom));
    step(0, 1, 0, 8'($urandom));
    chk("uf_set", 42'(underflow), 42'd1);
    chk("uf_de", 42'({fpdlink_dout[27], fpdlink_dout[6]}), 42'd3);
    for (int i = 3; i < 40; i++) step(0, 1, 1, 8'($urandom));
    chk("uf_held", 42'(underflow), 42'd1);
    step(0, 1, 1, 8'($urandom));
    chk("uf_clear_fs", 42'({frame_start, underflow}), 42'b10);
    for (int i = 1; i < 40; i++) step(0, 1, 1'($urandom_range(0, 3) != 0), 8'($urandom));
    step(0, 1, 0, 8'($urandom));
    chk("uf_wins_fs", 42'({frame_start, underflow}), 42'b11);
    for (int i = 1; i < 11; i++) step(0, 1, 1, 8'($urandom));
    fs_cnt = 0;
    for (int i = 11; i < 40; i++) step(0, 0, 1, 8'($urandom));
    chk("en_frame_done", 42'(fs_cnt), 42'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'($urandom));
    chk("idle_dout", fpdlink_dout, 42'd0);
    chk("idle_ready", 42'(pix_ready), 42'd0);
    step(0, 1, 1, 8'($urandom));
    chk("restart_nofs", 42'(frame_start), 42'd0);
    step(0, 1, 1, 8'($urandom));
    chk("restart_fs", 42'(frame_start), 42'd1);
    step(0, 1, 0, 8'($urandom));
    for (int i = 2; i < 9; i++) step(0, 1, 1, 8'($urandom));
    chk("pre_rst_uf", 42'(underflow), 42'd1);
    step(1, 1, 1, 8'($urandom));
    chk("rst_outs", 42'({fpdlink_dout, frame_start, underflow} != 0), 42'd0);
    step(0, 1, 1, 8'($urandom));
    step(0, 1, 1, 8'($urandom));
    chk("rst_fresh_fs", 42'(frame_start), 42'd1);
    for (int i = 0; i < 50; i++) step(0, 1, 1'($urandom_range(0, 3) != 0), 8'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vout_fpdlink.md
Name: vout_fpdlink

Overview:
- Transmit-side counterpart of the dual-channel FPD-Link video input path.
- Generates panel timing (HSYNC/VSYNC/DE) for a dual-pixel (odd/even channel) LVDS link.
- Pulls Y4 pixel pairs from an upstream stream and expands them to grey RGB666.
- Packs everything into the 42-bit parallel word consumed by the FPD-Link output serializer (7 bits x 6 lanes).
- Bit mapping is exactly the inverse of the input-path unpacker, so a loopback through serializer and deserializer is lossless.

Parameters:
H_ACT, 800, active clocks per line (each clock = 2 pixels)
H_FP, 24, horizontal front porch clocks
H_SYNC, 16, hsync width clocks
H_BP, 40, horizontal back porch clocks
V_ACT, 1200, active lines per frame
V_FP, 3, vertical front porch lines
V_SYNC, 3, vsync width lines
V_BP, 20, vertical back porch lines

Ports:
clk  in  1  pixel-pair clock (serializer gclk domain)
rst  in  1  synchronous, active-high reset
en  in  1  run enable; sampled only at frame boundary
pix_data  in  8  {y_even[3:0], y_odd[3:0]}, two Y4 pixels
pix_valid  in  1  upstream has a pixel pair
pix_ready  out  1  pair consumed this cycle when pix_valid=1
frame_start  out  1  one-cycle pulse, first cycle of each frame
underflow  out  1  sticky: DE cycle with no valid pixel in current frame
fpdlink_dout  out  42  parallel word to serializer

Behaviour:
- Totals: H_TOT = H_ACT+H_FP+H_SYNC+H_BP; V_TOT = V_ACT+V_FP+V_SYNC+V_BP. Size counters to clog2 of the totals.
- Counters:
  - hcnt runs 0..H_TOT-1 and wraps to 0.
  - vcnt increments on each hcnt wrap and wraps 0 after V_TOT-1.
  - Segment order on both axes: active, front porch, sync, back porch.
- Timing decodes from the counters:
  - hact = hcnt<H_ACT; vact = vcnt<V_ACT.
  - hs = H_ACT+H_FP <= hcnt < H_ACT+H_FP+H_SYNC.
  - vs = V_ACT+V_FP <= vcnt < V_ACT+V_FP+V_SYNC, held for whole lines.
  - de = hact & vact.
  - All syncs are active high.
- Run control, two states IDLE / RUN:
  - Reset enters IDLE with hcnt=vcnt=0.
  - IDLE: counters held at 0, pix_ready=0, dout=0. Moves to RUN on the first cycle en=1.
  - RUN: counters advance every cycle. At hcnt=H_TOT-1 and vcnt=V_TOT-1, if en=0, go to IDLE with counters cleared; otherwise wrap.
  - en changes mid-frame never truncate a frame.
- frame_start is registered: asserted in the cycle fpdlink_dout carries hcnt=0, vcnt=0 of a RUN frame.
- Handshake:
  - pix_ready = RUN & de, decoded from the current counters.
  - A transfer occurs when pix_ready & pix_valid. No stall: timing never waits for upstream.
  - Upstream data offered outside pix_ready is not consumed.
- Pipeline: latency 1. The counter state of cycle N and the pixel accepted in cycle N appear on fpdlink_dout in cycle N+1. Every dout bit is a flop.
- Expansion: c6 = {y[3:0], y[3:2]}. r=g=b=c6 per pixel, odd uses y_odd, even uses y_even. 4'hF gives 6'h3F; 4'h8 gives 6'h22.
- Underflow:
  - If pix_ready=1 and pix_valid=0, that dout cycle carries DE=1 with all colour bits 0, and underflow is set.
  - underflow clears in the cycle frame_start pulses. A same-cycle new underflow wins over the clear.
- Packing of fpdlink_dout (odd channel in [41:21], even in [20:0]):
  - Odd: [40:35]=r[5:0]; [32:28]=g[5:1]; [41]=g[0]; [24:21]=b[5:2]; [34:33]=b[1:0]; [25]=hs; [26]=vs; [27]=de.
  - Even: [19:14]=r; [11:7]=g[5:1]; [20]=g[0]; [3:0]=b[5:2]; [13:12]=b[1:0]; [4]=hs; [5]=vs; [6]=de.
  - Colour bits are 0 whenever de=0.
- Reset mid-frame: the next cycle has fpdlink_dout=0, underflow=0, frame_start=0, state IDLE, and no pixel consumed.

Test Plan:
Bench params throughout: H_ACT=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOT=8); V_ACT=2, V_FP=1, V_SYNC=1, V_BP=1 (V_TOT=5); frame = 40 clocks.
1. Timing: reset, en=1, pix_valid=1 → over each 40-cycle frame: exactly 8 de cycles; hs high at hcnt 5-6 of every line; vs high for all 8 cycles of line 3; frame_start every 40 cycles.
2. Packing: pix_data=8'hF0 accepted → next cycle odd colour bits all 0, even r/g/b all 6'h3F; dout[27]=dout[6]=1. Loop dout through the input-path unpacker and recover y_even=F, y_odd=0.
3. Latency/order: feed incrementing pix_data 0x00..0x07 with pix_valid=1 → each appears on dout exactly 1 cycle after its pix_ready, no loss, no duplication.
4. Underflow: drop pix_valid on the 3rd active cycle → that dout has de=1 and colour=0, underflow=1 and held; clears on the next frame_start.
5. Enable: drop en at hcnt=3, vcnt=1 → the frame completes all 40 cycles, then dout=0 and pix_ready=0. Re-assert en → frame_start 1 cycle after the first RUN cycle.
6. Reset mid-active-line → next cycle dout=0, underflow=0; with en=1 held, a fresh frame starts from hcnt=0.
